gemm_result_writer: RTL

//  Drain side of the GEMM accumulator output buffer: pops finished 4-lane x 32-bit result rows.

---
 rtl/gemm_result_writer_pkg.sv | 17 +
 rtl/gemm_result_writer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gemm_result_writer_pkg.sv
// ============================================================================
// Module  : gemm_result_writer_pkg
// Brief   : Shared GEMM result-path constants and the accumulator row type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gemm_result_writer_pkg;

    localparam int GEMM_LANES = 4;
    localparam int GEMM_ACC_W = 32;

    typedef logic [GEMM_LANES-1:0][GEMM_ACC_W-1:0] acc_row_t;

endpackage

`default_nettype wire

// File: rtl/gemm_result_writer.sv
// ============================================================================
// Module  : gemm_result_writer
// Brief   : Drains accumulator result rows and stores each lane as one word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_result_writer
    import gemm_result_writer_pkg::*;
#(
    parameter int LANES  = GEMM_LANES,
    parameter int DWIDTH = GEMM_ACC_W,
    parameter int AWIDTH = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [AWIDTH-1:0]       base_addr,
    input  logic [AWIDTH-1:0]       row_stride,
    input  logic [CNT_W-1:0]        num_rows,
    output logic                    busy,
    output logic                    done,
    output logic                    buf_rd_en,
    input  logic                    buf_empty,
    input  logic [LANES*DWIDTH-1:0] buf_data,
    output logic                    mem_req,
    output logic [AWIDTH-1:0]       mem_addr,
    output logic [DWIDTH-1:0]       mem_wdata,
    input  logic                    mem_ack
);

    localparam int                  c_lane_w    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(LANES - 1);
    localparam logic [c_lane_w-1:0] c_lane_one  = c_lane_w'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                         r_state;
    logic [AWIDTH-1:0]              r_row_addr;
    logic [AWIDTH-1:0]              r_stride;
    logic [CNT_W-1:0]               r_rows_left;
    logic [c_lane_w-1:0]            r_lane;
    logic [LANES-1:0][DWIDTH-1:0]   r_row;

    logic [c_lane_w-1:0]            w_lane_nxt;
    logic [AWIDTH-1:0]              w_word_addr;

    assign w_lane_nxt  = r_lane + c_lane_one;
    assign w_word_addr = r_row_addr + (AWIDTH'(w_lane_nxt) << 2);

    // Pop is qualified by buf_empty combinationally so an empty pop is impossible
    // and the popped data lands exactly in the CAP cycle.
    assign buf_rd_en = (r_state == S_POP) && !buf_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row_addr  <= '0;
            r_stride    <= '0;
            r_rows_left <= '0;
            r_lane      <= '0;
            r_row       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row_addr  <= base_addr;
                        r_stride    <= row_stride;
                        r_rows_left <= num_rows;
                        busy        <= 1'b1;
                        r_state     <= (num_rows == '0) ? S_FIN : S_POP;
                    end
                end
                S_POP: begin
                    if (!buf_empty) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_row     <= buf_data;
                    r_lane    <= '0;
                    mem_req   <= 1'b1;
                    mem_addr  <= r_row_addr;
                    mem_wdata <= buf_data[DWIDTH-1:0];
                    r_state   <= S_WR;
                end
                S_WR: begin
                    if (mem_ack) begin
                        if (r_lane == c_last_lane) begin
                            mem_req     <= 1'b0;
                            r_row_addr  <= r_row_addr + r_stride;
                            r_rows_left <= r_rows_left - CNT_W'(1);
                            r_state     <= (r_rows_left == CNT_W'(1)) ? S_FIN : S_POP;
                        end else begin
                            r_lane    <= w_lane_nxt;
                            mem_addr  <= w_word_addr;
                            mem_wdata <= r_row[w_lane_nxt];
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
